// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - Per-key synchronizer, debouncer and press/release pulse generator with lowest-index press arbitration.
// Optional auto-repeat of press pulses under KEY_CONDITIONER_REPEAT_EN.
module key_conditioner #(
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                clk,
    input  logic                system_reset_n,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic                lock_out,
    output logic [NUM_KEYS-1:0] held,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse
);
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} key_state_e;

    key_state_e          state_q [NUM_KEYS];
    key_state_e          state_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] sync1_q, sync1_d;
    logic [NUM_KEYS-1:0] sync2_q, sync2_d;
    logic [CW-1:0]       cnt_q [NUM_KEYS];
    logic [CW-1:0]       cnt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] accept;
    logic [NUM_KEYS-1:0] press_cand;
    logic [NUM_KEYS-1:0] repeat_cand;
    logic                pick_done;
    logic [NUM_KEYS-1:0] press_pulse_q, press_pulse_d;
    logic [NUM_KEYS-1:0] release_pulse_q, release_pulse_d;

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end

    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
    end

    // Counter holds how many consecutive cycles sync has disagreed with the stable level.
    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            cnt_d[k]  = '0;
            accept[k] = 1'b0;
            if (sync2_q[k] != (state_q[k] == RELEASED)) begin
                if (cnt_q[k] == DB_LAST) begin
                    accept[k] = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            state_d[k] = state_q[k];
            if (accept[k]) begin
                state_d[k] = (state_q[k] == PRESSED) ? RELEASED : PRESSED;
            end
        end
    end

`ifdef KEY_CONDITIONER_REPEAT_EN
    localparam int            RMAX       = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW         = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RPT_DELAY  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_PERIOD = RW'(REPEAT_PERIOD);

    logic [RW-1:0]       rep_cnt_q [NUM_KEYS];
    logic [RW-1:0]       rep_cnt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] rep_first_q, rep_first_d;

    // Timer only runs while a key stays pressed across the edge and nothing locks it out.
    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            rep_cnt_d[k]   = '0;
            rep_first_d[k] = 1'b1;
            repeat_cand[k] = 1'b0;
            if (state_q[k] == PRESSED && state_d[k] == PRESSED && !lock_out) begin
                rep_first_d[k] = rep_first_q[k];
                rep_cnt_d[k]   = rep_cnt_q[k] + RW'(1);
                if (rep_cnt_d[k] == (rep_first_q[k] ? RPT_DELAY : RPT_PERIOD)) begin
                    repeat_cand[k] = 1'b1;
                    rep_cnt_d[k]   = '0;
                    rep_first_d[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            rep_first_q <= '1;
            for (int k = 0; k < NUM_KEYS; k++) begin
                rep_cnt_q[k] <= '0;
            end
        end else begin
            rep_first_q <= rep_first_d;
            for (int k = 0; k < NUM_KEYS; k++) begin
                rep_cnt_q[k] <= rep_cnt_d[k];
            end
        end
    end
`else
    assign repeat_cand = '0;

    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be positive");
    end
`endif

    // Losing candidates are dropped outright; lock_out discards every candidate.
    always_comb begin
        press_cand      = '0;
        release_pulse_d = '0;
        press_pulse_d   = '0;
        pick_done       = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            press_cand[k]      = (accept[k] && state_q[k] == RELEASED) || repeat_cand[k];
            release_pulse_d[k] = accept[k] && state_q[k] == PRESSED;
        end
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (press_cand[k] && !pick_done && !lock_out) begin
                press_pulse_d[k] = 1'b1;
                pick_done        = 1'b1;
            end
        end
        for (int k = 0; k < NUM_KEYS; k++) begin
            held[k] = (state_q[k] == PRESSED);
        end
    end

    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;

    always_ff @(posedge clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            sync1_q         <= '1;
            sync2_q         <= '1;
            press_pulse_q   <= '0;
            release_pulse_q <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= RELEASED;
                cnt_q[k]   <= '0;
            end
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end
endmodule
